spine_output_arbiter: RTL and testbench

Per-output-port arbiter for the 11-port spine router. Shares one output port (leaf or group link) among all input ports whose head flit is routed to it, using round-robin, packet-locked (wormhole) arbitration. It muxes the winning input's flits into the output port FIFO under full-backpressure, pops the winner's input FIFO, and supervises stalled owners with a timeout. One instance sits in front of each output port's out-FIFO.

---
 rtl/spine_output_arbiter.sv | 140 ++++++++++++++
 tb/tb_spine_output_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spine_output_arbiter.sv
// Per-output-port round-robin wormhole arbiter for the spine router.
// Locks the output to one input for a whole packet and drops owners that starve too long.
module spine_output_arbiter #(
    parameter int NUM_PORTS = 11,
    parameter int DWIDTH    = 16,
    parameter int TIMEOUT   = 64,
    parameter int SELW      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_last,
    input  logic [NUM_PORTS*DWIDTH-1:0] in_data,
    input  logic                        out_fifo_full,
    output logic [NUM_PORTS-1:0]        grant,
    output logic [DWIDTH-1:0]           out_data,
    output logic                        out_valid,
    output logic [SELW-1:0]             owner,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [15:0]                 pkt_cnt
);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] STALL_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] STALL_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t              state_r, state_nx_s;
    logic [SELW-1:0]     owner_r, owner_nx_s;
    logic [SELW-1:0]     last_win_r, last_win_nx_s, winner_s;
    logic [CW-1:0]       stall_cnt_r, stall_cnt_nx_s;
    logic                timeout_err_r, timeout_err_nx_s;
    logic [15:0]         pkt_cnt_r, pkt_cnt_nx_s;
    logic [NUM_PORTS-1:0] owner_oh_s;
    logic                owner_valid_s, owner_last_s, xfer_s;
    logic [DWIDTH-1:0]   owner_data_s;
    int                  sum_s, idx_s;

    // Owner's request, last flag and head flit, selected through a one-hot mask.
    always_comb begin
        owner_oh_s    = ONE_HOT0 << owner_r;
        owner_valid_s = |(req_valid & owner_oh_s);
        owner_last_s  = |(req_last & owner_oh_s);
        owner_data_s  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            owner_data_s = owner_data_s | ({DWIDTH{owner_oh_s[i]}} & in_data[i*DWIDTH +: DWIDTH]);
        end
        xfer_s = (state_r == LOCK) & owner_valid_s & ~out_fifo_full;
    end

    // Round-robin search: scanning backwards leaves the nearest requester after last_win.
    always_comb begin
        winner_s = last_win_r;
        sum_s    = 0;
        idx_s    = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            sum_s    = int'(last_win_r) + k;
            idx_s    = (sum_s >= NUM_PORTS) ? (sum_s - NUM_PORTS) : sum_s;
            winner_s = (|(req_valid & (ONE_HOT0 << idx_s))) ? SELW'(idx_s) : winner_s;
        end
    end

    // Next-state logic for arbitration, packet lock and owner starvation.
    always_comb begin
        state_nx_s       = state_r;
        owner_nx_s       = owner_r;
        last_win_nx_s    = last_win_r;
        stall_cnt_nx_s   = stall_cnt_r;
        timeout_err_nx_s = timeout_err_r;
        pkt_cnt_nx_s     = pkt_cnt_r;
        case (state_r)
            IDLE: begin
                if (|req_valid) begin
                    state_nx_s     = LOCK;
                    owner_nx_s     = winner_s;
                    last_win_nx_s  = winner_s;
                    stall_cnt_nx_s = '0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOCK: begin
                if (xfer_s) begin
                    stall_cnt_nx_s = '0;
                    if (owner_last_s) begin
                        pkt_cnt_nx_s = pkt_cnt_r + 16'd1;
                        state_nx_s   = IDLE;
                    end else begin
                        state_nx_s = LOCK;
                    end
                end else if (!owner_valid_s) begin
                    // Starved owner: the TIMEOUT-th consecutive empty cycle abandons the packet.
                    if ((TIMEOUT != 0) && (stall_cnt_r == STALL_LAST)) begin
                        timeout_err_nx_s = 1'b1;
                        state_nx_s       = IDLE;
                    end else if (stall_cnt_r != STALL_MAX) begin
                        stall_cnt_nx_s = stall_cnt_r + CW'(1'b1);
                    end else begin
                        stall_cnt_nx_s = stall_cnt_r;
                    end
                end else begin
                    stall_cnt_nx_s = '0;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State registers; reset makes port 0 the first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            owner_r       <= '0;
            last_win_r    <= SELW'(NUM_PORTS - 1);
            stall_cnt_r   <= '0;
            timeout_err_r <= 1'b0;
            pkt_cnt_r     <= 16'd0;
        end else begin
            state_r       <= state_nx_s;
            owner_r       <= owner_nx_s;
            last_win_r    <= last_win_nx_s;
            stall_cnt_r   <= stall_cnt_nx_s;
            timeout_err_r <= timeout_err_nx_s;
            pkt_cnt_r     <= pkt_cnt_nx_s;
        end
    end

    assign grant       = xfer_s ? owner_oh_s : '0;
    assign out_valid   = xfer_s;
    assign out_data    = xfer_s ? owner_data_s : '0;
    assign owner       = owner_r;
    assign busy        = (state_r == LOCK);
    assign timeout_err = timeout_err_r;
    assign pkt_cnt     = pkt_cnt_r;

endmodule

// File: tb/tb_spine_output_arbiter.sv
// Bench for spine_output_arbiter: per-port flit sources, a packet-level reference
// model checked every cycle, and literal expectations for each directed scenario.
module tb_spine_output_arbiter;
    localparam int NP = 11;
    localparam int DW = 16;
    localparam int TO = 4;
    localparam int SW = 4;
    localparam logic [NP-1:0] ONE = {{(NP-1){1'b0}}, 1'b1};

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   req_valid, req_last;
    logic [NP*DW-1:0] in_data;
    logic            out_fifo_full;
    logic [NP-1:0]   grant;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic [SW-1:0]   owner;
    logic            busy, timeout_err;
    logic [15:0]     pkt_cnt;

    spine_output_arbiter #(.NUM_PORTS(NP), .DWIDTH(DW), .TIMEOUT(TO), .SELW(SW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
        .in_data(in_data), .out_fifo_full(out_fifo_full), .grant(grant),
        .out_data(out_data), .out_valid(out_valid), .owner(owner), .busy(busy),
        .timeout_err(timeout_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [NP-1:0] v, input int i);
        return |(v & (ONE << i));
    endfunction

    // Flit sources: one small array per input port, popped on grant.
    logic [16:0]   src_mem [NP][16];
    int            src_rd [NP];
    int            src_wr [NP];
    logic [NP-1:0] en_mask;

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_valid[i]       = en_mask[i];
                req_last[i]        = src_mem[i][src_rd[i]][16];
                in_data[i*DW +: DW] = src_mem[i][src_rd[i]][15:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                in_data[i*DW +: DW] = 16'h0000;
            end
        end
    endtask

    task automatic push(input int p, input logic [15:0] d, input logic last);
        src_mem[p][src_wr[p]] = {last, d};
        src_wr[p]++;
    endtask

    logic [15:0] log_d [$];
    int          log_p [$];
    logic [15:0] exp_d [$];

    task automatic clear_all();
        for (int i = 0; i < NP; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        log_d.delete();
        log_p.delete();
    endtask

    task automatic tick();
        logic [NP-1:0] g;
        @(negedge clk);
        g = grant;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (g[i] && (src_rd[i] < src_wr[i])) src_rd[i]++;
        end
        drive();
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, log_d.size(), exp_d.size());
        for (int k = 0; k < exp_d.size(); k++) begin
            if (k < log_d.size()) chk($sformatf("%s_%0d", nm, k), 32'(log_d[k]), 32'(exp_d[k]));
        end
    endtask

    // Reference model: packet-level view of the arbiter, advanced once per cycle.
    bit          m_init = 1'b0;
    bit          m_lock;
    int          m_owner, m_last, m_starve, m_pkt;
    bit          m_err;
    logic        e_xfer;
    logic [NP-1:0] e_grant;
    logic [DW-1:0] e_data;
    bit          found;

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            e_xfer  = m_lock && bit_of(req_valid, m_owner) && !out_fifo_full;
            e_grant = e_xfer ? (ONE << m_owner) : '0;
            e_data  = e_xfer ? DW'(in_data >> (m_owner * DW)) : '0;
            chk("grant", 32'(grant), 32'(e_grant));
            chk("out_valid", 32'(out_valid), 32'(e_xfer));
            chk("out_data", 32'(out_data), 32'(e_data));
            chk("owner", 32'(owner), m_owner);
            chk("busy", 32'(busy), 32'(m_lock));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
            chk("pkt_cnt", 32'(pkt_cnt), m_pkt);
            if (out_valid === 1'b1) begin
                log_d.push_back(out_data);
                log_p.push_back(-1);
                for (int i = 0; i < NP; i++) if (grant[i]) log_p[log_p.size()-1] = i;
            end
        end
        if (reset) begin
            m_init = 1'b1; m_lock = 1'b0; m_owner = 0; m_last = NP - 1;
            m_starve = 0; m_err = 1'b0; m_pkt = 0;
        end else if (m_init) begin
            if (!m_lock) begin
                if (req_valid != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NP; k++) begin
                        if (!found && bit_of(req_valid, (m_last + k) % NP)) begin
                            found = 1'b1;
                            m_owner = (m_last + k) % NP;
                        end
                    end
                    m_last = m_owner; m_lock = 1'b1; m_starve = 0;
                end
            end else if (bit_of(req_valid, m_owner)) begin
                m_starve = 0;
                if (!out_fifo_full && bit_of(req_last, m_owner)) begin
                    m_pkt  = (m_pkt + 1) % 65536;
                    m_lock = 1'b0;
                end
            end else begin
                m_starve++;
                if (TO != 0 && m_starve >= TO) begin
                    m_err  = 1'b1;
                    m_lock = 1'b0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1; out_fifo_full = 1'b0; en_mask = '1;
        req_valid = '0; req_last = '0; in_data = '0;
        clear_all();
        tick(); tick();
        reset = 1'b0;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_pkt", 32'(pkt_cnt), 32'h0);
        chk("rst_err", 32'(timeout_err), 32'h0);

        // Single requester, 3-flit packet on port 2
        clear_all();
        push(2, 16'hA001, 1'b0); push(2, 16'hA002, 1'b0); push(2, 16'hA003, 1'b1);
        drive();
        repeat (5) tick();
        exp_d = '{16'hA001, 16'hA002, 16'hA003};
        check_log("t1_data");
        if (log_p.size() > 0) chk("t1_port", log_p[0], 2);
        chk("t1_pkt", 32'(pkt_cnt), 32'd1);
        chk("t1_busy", 32'(busy), 32'h0);

        // Round robin with every port holding two 1-flit packets; last winner was 2
        clear_all();
        for (int p = 0; p < NP; p++) begin
            push(p, 16'hB000 + 16'(p * 16), 1'b1);
            push(p, 16'hB000 + 16'(p * 16 + 1), 1'b1);
        end
        drive();
        repeat (46) tick();
        chk("t2_len", log_p.size(), 2 * NP);
        for (int k = 0; k < log_p.size(); k++) begin
            chk($sformatf("t2_port_%0d", k), log_p[k], (3 + k) % NP);
            chk($sformatf("t2_data_%0d", k), 32'(log_d[k]),
                32'(16'hB000 + 16'(((3 + k) % NP) * 16 + (k / NP))));
        end
        chk("t2_pkt", 32'(pkt_cnt), 32'd23);

        // Backpressure on owner 5 for four cycles
        clear_all();
        push(5, 16'hC001, 1'b0); push(5, 16'hC002, 1'b0);
        push(5, 16'hC003, 1'b0); push(5, 16'hC004, 1'b1);
        drive();
        tick(); tick();
        out_fifo_full = 1'b1;
        repeat (4) tick();
        chk("t3_busy_full", 32'(busy), 32'h1);
        chk("t3_owner", 32'(owner), 32'd5);
        out_fifo_full = 1'b0;
        repeat (4) tick();
        exp_d = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        check_log("t3_data");
        chk("t3_pkt", 32'(pkt_cnt), 32'd24);
        chk("t3_err", 32'(timeout_err), 32'h0);

        // Owner 3 starves after its first flit; port 7 waits
        clear_all();
        push(3, 16'hD001, 1'b0); push(3, 16'hD002, 1'b0); push(3, 16'hD003, 1'b1);
        drive();
        tick(); tick();
        en_mask[3] = 1'b0;
        push(7, 16'hE001, 1'b1);
        drive();
        repeat (4) tick();
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_err", 32'(timeout_err), 32'h1);
        chk("t4_pkt", 32'(pkt_cnt), 32'd24);
        en_mask = '1;
        drive();
        tick();
        chk("t4_owner7", 32'(owner), 32'd7);
        repeat (5) tick();
        exp_d = '{16'hD001, 16'hE001, 16'hD002, 16'hD003};
        check_log("t4_data");
        chk("t4_pkt2", 32'(pkt_cnt), 32'd26);
        chk("t4_err_sticky", 32'(timeout_err), 32'h1);

        // Port 0 requests while owner 1 is mid-packet
        clear_all();
        push(1, 16'hF001, 1'b0); push(1, 16'hF002, 1'b0); push(1, 16'hF003, 1'b1);
        drive();
        tick(); tick();
        push(0, 16'hF100, 1'b1);
        drive();
        tick();
        chk("t5_nogrant0", 32'(grant[0]), 32'h0);
        chk("t5_owner1", 32'(owner), 32'd1);
        tick();
        chk("t5_bubble", 32'(busy), 32'h0);
        tick();
        chk("t5_owner0", 32'(owner), 32'd0);
        tick(); tick();
        exp_d = '{16'hF001, 16'hF002, 16'hF003, 16'hF100};
        check_log("t5_data");
        chk("t5_pkt", 32'(pkt_cnt), 32'd28);

        // Reset in the middle of a packet from port 4
        clear_all();
        push(4, 16'h4001, 1'b0); push(4, 16'h4002, 1'b0); push(4, 16'h4003, 1'b1);
        drive();
        tick(); tick();
        reset = 1'b1;
        tick();
        clear_all();
        reset = 1'b0;
        drive();
        chk("t6_grant", 32'(grant), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_owner", 32'(owner), 32'h0);
        chk("t6_pkt", 32'(pkt_cnt), 32'h0);
        chk("t6_err", 32'(timeout_err), 32'h0);
        push(0, 16'h9000, 1'b1); push(10, 16'h900A, 1'b1);
        drive();
        tick();
        chk("t6_first_owner", 32'(owner), 32'd0);
        chk("t6_first_busy", 32'(busy), 32'h1);
        repeat (4) tick();
        exp_d = '{16'h9000, 16'h900A};
        check_log("t6_data");
        chk("t6_pkt2", 32'(pkt_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
